// File: rtl/fringe_pattern_generator.sv
// Fringe pattern generator: AXI4-Stream master emitting a signed triangle wave.
// Optional build macro FRINGE_GEN_NOISE_EN adds LFSR noise to emitted samples.
module fringe_pattern_generator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int RATE_DIV_WIDTH   = 16
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_areset,
    input  logic                        FC_enable,
    input  logic [AXIS_TDATA_WIDTH-1:0] FC_lower_limit,
    input  logic [AXIS_TDATA_WIDTH-1:0] FC_upper_limit,
    input  logic [AXIS_TDATA_WIDTH-1:0] FC_step,
    input  logic [RATE_DIV_WIDTH-1:0]   FC_rate_div,
    output logic                        FC_error,
    output logic [31:0]                 STAT_period_count,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    localparam int TDW = AXIS_TDATA_WIDTH;
    localparam int RDW = RATE_DIV_WIDTH;

    typedef enum logic [1:0] {IDLE, RISE, FALL, GAP} state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [TDW-1:0]   lo_q, lo_d;
    logic [TDW-1:0]   hi_q, hi_d;
    logic [TDW-1:0]   st_q, st_d;
    logic [TDW-1:0]   tri_q, tri_d;
    logic [TDW-1:0]   tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             err_q, err_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [RDW-1:0]   div_q, div_d;

    logic [TDW-1:0]   noise;
    logic signed [TDW:0] up_x, dn_x;
    logic             hs, cfg_ok, rise, up_hit, dn_hit;
    logic [TDW-1:0]   nxt;
    logic             nxt_dir, wrap;

`ifdef FRINGE_GEN_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign noise = {{(TDW-4){lfsr_q[3]}}, lfsr_q[3:0]};

    // Galois LFSR steps once per accepted beat
    always_comb begin
        lfsr_d = lfsr_q;
        if (hs) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // LFSR register, reseeded on reset
    always_ff @(posedge SYS_aclk) begin
        if (SYS_areset) lfsr_q <= 16'hACE1;
        else            lfsr_q <= lfsr_d;
    end
`else
    assign noise = '0;
`endif

    // Adds noise to a triangle value, clamping to the signed sample range
    function automatic logic [TDW-1:0] emit(input logic [TDW-1:0] v,
                                            input logic [TDW-1:0] n);
        logic [TDW:0] s;
        s = {v[TDW-1], v} + {n[TDW-1], n};
        if (s[TDW] != s[TDW-1]) begin
            emit = s[TDW] ? {1'b1, {(TDW-1){1'b0}}} : {1'b0, {(TDW-1){1'b1}}};
        end else begin
            emit = s[TDW-1:0];
        end
    endfunction

    assign hs     = tvalid_q && M_AXIS_tready;
    assign cfg_ok = ($signed(FC_lower_limit) < $signed(FC_upper_limit)) &&
                    ($signed(FC_step) > 0);
    assign rise   = (state_q == RISE);
    assign up_x   = {tri_q[TDW-1], tri_q} + {st_q[TDW-1], st_q};
    assign dn_x   = {tri_q[TDW-1], tri_q} - {st_q[TDW-1], st_q};
    assign up_hit = up_x >= $signed({hi_q[TDW-1], hi_q});
    assign dn_hit = dn_x <= $signed({lo_q[TDW-1], lo_q});
    assign nxt    = rise ? (up_hit ? hi_q : up_x[TDW-1:0])
                         : (dn_hit ? lo_q : dn_x[TDW-1:0]);
    assign nxt_dir = rise ? !up_hit : dn_hit;
    assign wrap    = !rise && dn_hit;

    // Next-state and output logic of the waveform sequencer
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        st_d     = st_q;
        tri_d    = tri_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        unique case (state_q)
            IDLE: begin
                if (FC_enable) begin
                    if (cfg_ok) begin
                        lo_d     = FC_lower_limit;
                        hi_d     = FC_upper_limit;
                        st_d     = FC_step;
                        tri_d    = FC_lower_limit;
                        tdata_d  = emit(FC_lower_limit, noise);
                        tvalid_d = 1'b1;
                        err_d    = 1'b0;
                        dir_d    = 1'b1;
                        state_d  = RISE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RISE, FALL: begin
                if (hs) begin
                    if (!FC_enable) begin
                        tvalid_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        tri_d = nxt;
                        dir_d = nxt_dir;
                        if (wrap) cnt_d = cnt_q + 32'd1;
                        if (FC_rate_div == '0) begin
                            tdata_d = emit(nxt, noise);
                            state_d = nxt_dir ? RISE : FALL;
                        end else begin
                            tvalid_d = 1'b0;
                            div_d    = FC_rate_div;
                            state_d  = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (!FC_enable) begin
                    state_d = IDLE;
                end else if (div_q == RDW'(1)) begin
                    tdata_d  = emit(tri_q, noise);
                    tvalid_d = 1'b1;
                    state_d  = dir_q ? RISE : FALL;
                end else begin
                    div_d = div_q - RDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge SYS_aclk) begin
        if (SYS_areset) begin
            state_q  <= IDLE;
            dir_q    <= 1'b1;
            lo_q     <= '0;
            hi_q     <= '0;
            st_q     <= '0;
            tri_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            st_q     <= st_d;
            tri_q    <= tri_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
        end
    end

    assign FC_error          = err_q;
    assign STAT_period_count = cnt_q;
    assign M_AXIS_tvalid     = tvalid_q;
    assign M_AXIS_tdata      = tdata_q;

endmodule

// File: tb/tb_fringe_pattern_generator.sv
// Bench for fringe_pattern_generator: directed and randomized streams
// scored against a period-list reference model.
module tb_fringe_pattern_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] lo_i, hi_i, st_i;
    logic [15:0] rate_i;
    logic        err;
    logic [31:0] cnt;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;

    int vec  = 0;
    int miss = 0;
    int q_v[$];
    int q_c[$];

    always #5 clk = ~clk;

    fringe_pattern_generator dut (
        .SYS_aclk          (clk),
        .SYS_areset        (rst),
        .FC_enable         (en),
        .FC_lower_limit    (lo_i),
        .FC_upper_limit    (hi_i),
        .FC_step           (st_i),
        .FC_rate_div       (rate_i),
        .FC_error          (err),
        .STAT_period_count (cnt),
        .M_AXIS_tvalid     (tvalid),
        .M_AXIS_tready     (tready),
        .M_AXIS_tdata      (tdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one period = ascending run to upper, descending run above lower.
    // Each sample carries the index of the period it belongs to.
    task automatic build(input longint lo, input longint hi, input longint st,
                         input int need);
        int p;
        p = 0;
        q_v.delete();
        q_c.delete();
        while (q_v.size() < need) begin
            for (longint v = lo; v < hi; v += st) begin
                q_v.push_back(int'(v));
                q_c.push_back(p);
            end
            q_v.push_back(int'(hi));
            q_c.push_back(p);
            for (longint v = hi - st; v > lo; v -= st) begin
                q_v.push_back(int'(v));
                q_c.push_back(p);
            end
            p++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int lo, input int hi, input int st, input int rate,
                       input int nb, input int mode);
        int k, cyc;
        logic rdy, stall;
        logic [31:0] held;
        build(lo, hi, st, nb + 2);
        do_reset();
        lo_i = lo;
        hi_i = hi;
        st_i = st;
        rate_i = rate[15:0];
        en = 1'b1;
        k = 0;
        cyc = 0;
        stall = 1'b0;
        held = '0;
        while (k < nb && cyc < 64 * nb + 64) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: rdy = 1'b1;
                1: rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (stall) begin
                chk("hold_valid", tvalid, 1);
                chk("hold_data", tdata, held);
            end
            if (tvalid) begin
                chk("data", tdata, q_v[k]);
                chk("pcount", cnt, q_c[k]);
            end
            stall = tvalid && !rdy;
            held = tdata;
            tready = rdy;
            if (tvalid && rdy) k++;
        end
        if (k < nb) chk("timeout_stream", k, nb);
        @(negedge clk);
        tready = 1'b0;
        cyc = 0;
        while (!tvalid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk("stop_valid", tvalid, 1);
        chk("stop_data", tdata, q_v[k]);
        en = 1'b0;
        @(negedge clk);
        chk("stop_held_v", tvalid, 1);
        chk("stop_held_d", tdata, q_v[k]);
        tready = 1'b1;
        @(negedge clk);
        chk("stop_idle", tvalid, 0);
        @(negedge clk);
        chk("stop_idle2", tvalid, 0);
    endtask

    initial begin
        lo_i = '0;
        hi_i = '0;
        st_i = '0;
        rate_i = '0;
        do_reset();
        chk("rst_valid", tvalid, 0);
        chk("rst_data", tdata, 0);
        chk("rst_err", err, 0);
        chk("rst_count", cnt, 0);

        run(-15, 15, 5, 0, 13, 0);
        run(-15, 15, 5, 0, 13, 1);

        do_reset();
        lo_i = -15;
        hi_i = 15;
        st_i = 5;
        rate_i = 16'd2;
        tready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("rate_valid", tvalid, (i % 3 == 0));
            if (i % 3 == 0) chk("rate_data", tdata, -15 + 5 * (i / 3));
        end

        do_reset();
        lo_i = 10;
        hi_i = -10;
        st_i = 5;
        rate_i = '0;
        tready = 1'b1;
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bad_order_err", err, 1);
        chk("bad_order_valid", tvalid, 0);
        lo_i = -10;
        hi_i = 10;
        st_i = 0;
        @(negedge clk);
        chk("zero_step_err", err, 1);
        chk("zero_step_valid", tvalid, 0);
        st_i = 5;
        @(negedge clk);
        chk("good_err", err, 0);
        chk("good_valid", tvalid, 1);
        chk("good_data", tdata, -10);
        en = 1'b0;
        @(negedge clk);
        chk("good_stop", tvalid, 0);

        run(-15, 15, 40, 0, 8, 0);
        run(32'h8000_0000, 32'h7fff_ffff, 32'h7fff_ffff, 0, 12, 0);
        run(-3, 3, 1, 1, 16, 2);

        do_reset();
        lo_i = -15;
        hi_i = 15;
        st_i = 40;
        rate_i = '0;
        tready = 1'b1;
        en = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_count", cnt, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", tvalid, 0);
        chk("mid_rst_data", tdata, 0);
        chk("mid_rst_count", cnt, 0);
        rst = 1'b0;
        en = 1'b0;

        for (int r = 0; r < 8; r++) begin
            int lo, span, st, rate;
            lo = int'($urandom_range(0, 2000)) - 1000;
            span = int'($urandom_range(1, 2000));
            st = int'($urandom_range(1, 300));
            rate = int'($urandom_range(0, 3));
            run(lo, lo + span, st, rate, 25, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
